nrd_pipe: RTL and testbench

Parametrised, pipelined non-restoring unsigned divider with valid/ready flow control and a pass-through tag. It retires WIDTH quotient bits over WIDTH/BPS iteration stages plus one remainder-correction stage, and accepts one new operand pair per cycle. It is the clocked successor to the team's fixed 24-bit combinational divider and sits between operand-issue logic and a result consumer that may apply backpressure.

---
 rtl/nrd_pipe_if.sv | 41 ++++
 rtl/nrd_pipe.sv | 143 ++++++++++++++
 tb/tb_nrd_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nrd_pipe_if.sv
// nrd_pipe_if: operand-issue and result-consume bundle for nrd_pipe.
// master = issuer/consumer side, slave = divider side.
// The div0 signal exists only when NRDP_DIV0_FLAG_EN is defined.
interface nrd_pipe_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [TAG_W-1:0] out_tag;
`ifdef NRDP_DIV0_FLAG_EN
  logic             div0;

  modport master (
    output in_valid, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quo, rem, out_tag, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quo, rem, out_tag, div0
  );
`else
  modport master (
    output in_valid, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quo, rem, out_tag
  );

  modport slave (
    input  in_valid, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quo, rem, out_tag
  );
`endif
endinterface

// File: rtl/nrd_pipe.sv
// nrd_pipe: pipelined non-restoring unsigned divider with valid/ready flow control.
// Stage 0 registers the operands, WIDTH/BPS iteration stages each retire BPS quotient
// bits, and a final stage applies the remainder correction. All stages advance on a
// single global enable, so a stalled consumer freezes the whole pipe.
// Optional feature macro: NRDP_DIV0_FLAG_EN adds a per-operation divide-by-zero flag.
module nrd_pipe #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned BPS   = 1,
  parameter int unsigned TAG_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  nrd_pipe_if.slave bus
);

  localparam int unsigned NSTG = WIDTH / BPS;

  if ((WIDTH < 2) || (BPS < 1) || ((WIDTH % BPS) != 0) || (TAG_W < 1)) begin : gen_cfg_err
    $error("nrd_pipe: WIDTH must be >= 2 and a multiple of BPS, TAG_W >= 1");
  end

  // BPS non-restoring steps; the operation is chosen by the sign before the shift so
  // that a transient overflow of the shifted value wraps harmlessly.
  function automatic logic [2*WIDTH:0] nrd_steps(input logic [WIDTH:0]   a_in,
                                                 input logic [WIDTH-1:0] q_in,
                                                 input logic [WIDTH-1:0] m_in);
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m_ext;
    logic             neg;
    a     = a_in;
    q     = q_in;
    m_ext = {1'b0, m_in};
    for (int unsigned s = 0; s < BPS; s++) begin
      neg  = a[WIDTH];
      a    = {a[WIDTH-1:0], q[WIDTH-1]};
      q    = {q[WIDTH-2:0], 1'b0};
      a    = neg ? (a + m_ext) : (a - m_ext);
      q[0] = ~a[WIDTH];
    end
    return {a, q};
  endfunction

  logic en;

  // Slot 0 is the operand register, slots 1..NSTG hold iteration results.
  logic [WIDTH:0]   a_q   [0:NSTG];
  logic [WIDTH-1:0] q_q   [0:NSTG];
  logic [WIDTH-1:0] m_q   [0:NSTG];
  logic [TAG_W-1:0] tag_q [0:NSTG];
  logic [NSTG:0]    vld_q;

  logic [WIDTH:0]   a_d   [1:NSTG];
  logic [WIDTH-1:0] q_d   [1:NSTG];

  logic [WIDTH-1:0] rem_d;

  logic             ovld_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [TAG_W-1:0] otag_q;

  // Global advance: bubbles are squeezed out only by the consumer side.
  assign en           = ~ovld_q | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar i = 1; i <= NSTG; i++) begin : gen_stage
    assign {a_d[i], q_d[i]} = nrd_steps(a_q[i-1], q_q[i-1], m_q[i-1]);
  end

  // Remainder correction; only the low WIDTH bits survive, so modular adds suffice.
  always_comb begin
    rem_d = a_q[NSTG][WIDTH-1:0];
    if (a_q[NSTG][WIDTH]) begin
      rem_d = a_q[NSTG][WIDTH-1:0] + m_q[NSTG];
    end
  end

  // Operand capture and iteration pipeline, all slots shift together on en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i <= NSTG; i++) begin
        a_q[i]   <= '0;
        q_q[i]   <= '0;
        m_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      a_q[0]   <= '0;
      q_q[0]   <= bus.dividend;
      m_q[0]   <= bus.divisor;
      tag_q[0] <= bus.in_tag;
      for (int unsigned i = 1; i <= NSTG; i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_d[i];
        q_q[i]   <= q_d[i];
        m_q[i]   <= m_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Output register: corrected result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovld_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      otag_q <= '0;
    end else if (en) begin
      ovld_q <= vld_q[NSTG];
      quo_q  <= q_q[NSTG];
      rem_q  <= rem_d;
      otag_q <= tag_q[NSTG];
    end
  end

  assign bus.out_valid = ovld_q;
  assign bus.quo       = quo_q;
  assign bus.rem       = rem_q;
  assign bus.out_tag   = otag_q;

`ifdef NRDP_DIV0_FLAG_EN
  logic [NSTG:0] z_q;
  logic          div0_q;

  // Divide-by-zero flag travels with its operation through every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= '0;
      div0_q <= 1'b0;
    end else if (en) begin
      z_q    <= {z_q[NSTG-1:0], (bus.divisor == '0)};
      div0_q <= z_q[NSTG];
    end
  end

  assign bus.div0 = div0_q & ovld_q;
`endif

endmodule

// File: tb/tb_nrd_pipe.sv
// tb_nrd_pipe: directed bench for nrd_pipe (24/1 and 16/4 instances).
// Define NRDP_DIV0_FLAG_EN on the command line to also check the div0 flag.
module tb_nrd_pipe;

  typedef struct packed {
    logic [23:0] quo;
    logic [23:0] rem;
    logic [3:0]  tag;
    logic        z;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  exp_t        sb[$];
  logic [23:0] op_a[$];
  logic [23:0] op_b[$];
  logic [3:0]  next_tag = 4'd0;

  nrd_pipe_if #(.WIDTH(24), .TAG_W(4)) b24 ();
  nrd_pipe_if #(.WIDTH(16), .TAG_W(4)) b16 ();

  nrd_pipe #(.WIDTH(24), .BPS(1), .TAG_W(4)) u_dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b24)
  );

  nrd_pipe #(.WIDTH(16), .BPS(4), .TAG_W(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t golden(input logic [23:0] a, input logic [23:0] b,
                                  input logic [3:0] t);
    exp_t e;
    e.tag = t;
    e.z   = (b == 24'd0);
    if (b == 24'd0) begin
      e.quo = 24'hFFFFFF;
      e.rem = a;
    end else begin
      e.quo = a / b;
      e.rem = a % b;
    end
    return e;
  endfunction

  // Drives op_a/op_b through the 24-bit instance, optionally stalling the consumer.
  task automatic run_stream(input int stall_at, input int stall_len, input bit check_rate);
    int          idx = 0;
    int          cyc = 0;
    int          npop = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    bit          held = 1'b0;
    logic [23:0] hq, hr;
    logic [3:0]  ht;
    exp_t        e;
    int          n;
    n = op_a.size();
    while ((idx < n || sb.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      b24.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      b24.in_valid  = (idx < n);
      if (idx < n) begin
        b24.dividend = op_a[idx];
        b24.divisor  = op_b[idx];
        b24.in_tag   = next_tag;
      end
      #1;
      if (b24.out_valid && !b24.out_ready) begin
        check_eq("stall_in_ready", {63'd0, b24.in_ready}, 64'd0);
        if (held) begin
          check_eq("stall_quo", {40'd0, b24.quo}, {40'd0, hq});
          check_eq("stall_rem", {40'd0, b24.rem}, {40'd0, hr});
          check_eq("stall_tag", {60'd0, b24.out_tag}, {60'd0, ht});
        end else begin
          hq   = b24.quo;
          hr   = b24.rem;
          ht   = b24.out_tag;
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
      if (b24.out_valid && b24.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("quo", {40'd0, b24.quo}, {40'd0, e.quo});
          check_eq("rem", {40'd0, b24.rem}, {40'd0, e.rem});
          check_eq("tag", {60'd0, b24.out_tag}, {60'd0, e.tag});
`ifdef NRDP_DIV0_FLAG_EN
          check_eq("div0", {63'd0, b24.div0}, {63'd0, e.z});
`endif
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          npop++;
        end
      end
      if (b24.in_valid && b24.in_ready) begin
        sb.push_back(golden(op_a[idx], op_b[idx], next_tag));
        idx++;
        next_tag = next_tag + 4'd1;
      end
      cyc++;
    end
    check_eq("stream_done", {63'd0, (cyc < 2000)}, 64'd1);
    if (check_rate) check_eq("rate", 64'(last_pop - first_pop), 64'(npop - 1));
    @(negedge clk);
    b24.in_valid  = 1'b0;
    b24.out_ready = 1'b1;
    // No duplicate or leftover results after the queue drains.
    npop = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b24.out_valid) npop++;
    end
    check_eq("drain_empty", 64'(npop), 64'd0);
    op_a.delete();
    op_b.delete();
  endtask

  initial begin
    int cyc;
    int seen;
    logic [23:0] ra, rb;

    b24.in_valid = 1'b0; b24.dividend = '0; b24.divisor = '0; b24.in_tag = '0;
    b24.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.dividend = '0; b16.divisor = '0; b16.in_tag = '0;
    b16.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    #3;
    check_eq("rst_out_valid", {63'd0, b24.out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, b24.in_ready}, 64'd1);
    check_eq("rst_quo", {40'd0, b24.quo}, 64'd0);
    check_eq("rst_rem", {40'd0, b24.rem}, 64'd0);
    check_eq("rst_tag", {60'd0, b24.out_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single operation latency: 100 / 7, tag 3
    @(negedge clk);
    b24.in_valid = 1'b1; b24.dividend = 24'd100; b24.divisor = 24'd7; b24.in_tag = 4'd3;
    @(negedge clk);
    b24.in_valid = 1'b0;
    cyc = 0;
    while (!b24.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("lat24", 64'(cyc), 64'd25);
    check_eq("q100_7", {40'd0, b24.quo}, 64'd14);
    check_eq("r100_7", {40'd0, b24.rem}, 64'd2);
    check_eq("t100_7", {60'd0, b24.out_tag}, 64'd3);
    @(negedge clk);

    // Back-to-back stream of 50 operations with boundary cases first
    op_a.push_back(24'hFFFFFF); op_b.push_back(24'd1);
    op_a.push_back(24'd5);      op_b.push_back(24'd9);
    op_a.push_back(24'h123456); op_b.push_back(24'd0);
    op_a.push_back(24'd100);    op_b.push_back(24'd7);
    op_a.push_back(24'hFFFFFF); op_b.push_back(24'hFFFFFF);
    op_a.push_back(24'd0);      op_b.push_back(24'd3);
    for (int i = 0; i < 44; i++) begin
      ra = 24'($urandom());
      rb = (i % 3 == 0) ? 24'($urandom_range(1, 255)) : 24'($urandom());
      if (rb == 24'd0) rb = 24'd1;
      op_a.push_back(ra);
      op_b.push_back(rb);
    end
    run_stream(100000, 0, 1'b1);

    // Backpressure: stall 10 cycles with the pipe full
    for (int i = 0; i < 30; i++) begin
      ra = 24'($urandom());
      rb = 24'($urandom_range(1, 4095));
      op_a.push_back(ra);
      op_b.push_back(rb);
    end
    run_stream(30, 10, 1'b0);

    // Reset with five operations in flight, the oldest held at the output
    @(negedge clk);
    b24.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b24.in_valid = 1'b1;
      b24.dividend = 24'(1000 + i);
      b24.divisor  = 24'd3;
      b24.in_tag   = 4'(i + 1);
      @(negedge clk);
    end
    b24.in_valid = 1'b0;
    cyc = 0;
    while (!b24.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_fill", {63'd0, b24.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, b24.out_valid}, 64'd0);
    check_eq("mid_rst_quo", {40'd0, b24.quo}, 64'd0);
    check_eq("mid_rst_rem", {40'd0, b24.rem}, 64'd0);
    check_eq("mid_rst_tag", {60'd0, b24.out_tag}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, b24.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    b24.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b24.out_valid) seen++;
    end
    check_eq("no_stale", 64'(seen), 64'd0);

    // 16-bit, 4 bits per stage: 1000 / 33
    @(negedge clk);
    b16.in_valid = 1'b1; b16.dividend = 16'd1000; b16.divisor = 16'd33; b16.in_tag = 4'd9;
    @(negedge clk);
    b16.in_valid = 1'b0;
    cyc = 0;
    while (!b16.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("lat16", 64'(cyc), 64'd5);
    check_eq("q1000_33", {48'd0, b16.quo}, 64'd30);
    check_eq("r1000_33", {48'd0, b16.rem}, 64'd10);
    check_eq("t1000_33", {60'd0, b16.out_tag}, 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
